// File: rtl/clk_phase_gen.sv
// Clock phase generator: locks a step counter to a sampled reference clock and
// derives NPH phase-shifted, optionally inverted clocks with rise strobes.
module clk_phase_gen #(
  parameter int DIV      = 16,
  parameter int NPH      = 4,
  parameter int LOCK_CNT = 4,
  parameter int TOL      = 1,
  localparam int PHW     = $clog2(DIV)
) (
  input  logic               CPUCLK_I,
  input  logic               rst,
  input  logic               ref_i,
  input  logic [NPH*PHW-1:0] phase_i,
  input  logic [NPH-1:0]     inv_i,
  output logic [NPH-1:0]     clk_o,
  output logic [NPH-1:0]     stb_o,
  output logic               locked,
  output logic [PHW-1:0]     pcnt_o
);
  localparam int WDW = PHW + 2;
  localparam logic [WDW-1:0] WD_MAX = WDW'(2 * DIV);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  function automatic logic [PHW-1:0] err_mag(input logic signed [PHW-1:0] e);
    return e[PHW-1] ? $unsigned(-e) : $unsigned(e);
  endfunction

  function automatic logic [WDW-1:0] wd_step(input logic [WDW-1:0] w);
    return (w == WD_MAX) ? w : w + WDW'(1);
  endfunction

  logic                  sync_p0, sync_p1, sync_p2;
  logic                  ref_rise;
  logic [PHW-1:0]        pcnt, pcnt_inc;
  logic signed [PHW-1:0] edge_err;
  logic                  edge_good;
  state_t                state, state_next;
  logic [3:0]            gcnt, gcnt_next, gcnt_inc;
  logic [WDW-1:0]        wd;
  logic                  wd_expire;
  logic [NPH*PHW-1:0]    ph_p0;
  logic                  locked_next;
  logic [NPH-1:0]        clk_next;

  // Reference synchroniser; the third flop only serves edge detection
  always_ff @(posedge CPUCLK_I or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= ref_i;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign ref_rise  = sync_p1 & ~sync_p2;
  assign pcnt_inc  = pcnt + PHW'(1);
  // A perfectly aligned edge arrives when pcnt is about to wrap to 0
  assign edge_err  = $signed(pcnt_inc);
  assign edge_good = err_mag(edge_err) <= PHW'(TOL);
  assign gcnt_inc  = gcnt + 4'd1;
  assign wd_expire = ~ref_rise & (wd_step(wd) == WD_MAX);

  always_comb begin
    state_next = state;
    gcnt_next  = gcnt;
    if (ref_rise) begin
      case (state)
        UNLOCKED: begin
          state_next = ACQUIRE;
          gcnt_next  = '0;
        end
        ACQUIRE: begin
          if (edge_good) begin
            gcnt_next = gcnt_inc;
            if (gcnt_inc == 4'(LOCK_CNT)) state_next = LOCKED;
          end else begin
            gcnt_next = '0;
          end
        end
        LOCKED: begin
          if (!edge_good) begin
            state_next = ACQUIRE;
            gcnt_next  = '0;
          end
        end
        default: begin
          state_next = UNLOCKED;
          gcnt_next  = '0;
        end
      endcase
    end else if (wd_expire) begin
      state_next = UNLOCKED;
      gcnt_next  = '0;
    end
  end

  always_ff @(posedge CPUCLK_I or posedge rst) begin
    if (rst) begin
      state <= UNLOCKED;
      gcnt  <= '0;
      wd    <= '0;
      pcnt  <= '0;
    end else begin
      state <= state_next;
      gcnt  <= gcnt_next;
      wd    <= ref_rise ? '0 : wd_step(wd);
      pcnt  <= ref_rise ? '0 : pcnt_inc;
    end
  end

  // Phase offsets only change at the period boundary so outputs never glitch
  always_ff @(posedge CPUCLK_I or posedge rst) begin
    if (rst) begin
      ph_p0 <= '0;
    end else if (pcnt == PHW'(DIV - 1)) begin
      ph_p0 <= phase_i;
    end
  end

  assign locked_next = (state == LOCKED);

  always_comb begin
    logic [PHW-1:0] diff;
    diff     = '0;
    clk_next = '0;
    for (int n = 0; n < NPH; n++) begin
      diff        = pcnt - ph_p0[n*PHW +: PHW];
      clk_next[n] = locked_next & (~diff[PHW-1] ^ inv_i[n]);
    end
  end

  // Output stage: every output is a flop
  always_ff @(posedge CPUCLK_I or posedge rst) begin
    if (rst) begin
      locked <= 1'b0;
      clk_o  <= '0;
      stb_o  <= '0;
    end else begin
      locked <= locked_next;
      clk_o  <= clk_next;
      stb_o  <= clk_next & ~clk_o;
    end
  end

  assign pcnt_o = pcnt;

endmodule
